alien_move: RTL and testbench

//  Movement controller for one alien; consumes terrain's free_direction_alien_a and produces the alien
//  top-left fed back into terrain and the alien drawer. Steps along a tile grid once per frame, choosing
//  at each tile boundary a free direction that closes on the player. Handles death and timed respawn.

---
 rtl/alien_move.sv | 275 +++++++++++++++++++++++++++
 tb/tb_alien_move.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alien_move.sv
// ---------------------------------------------------------------------------
// alien_move -- movement controller for one alien.
//
// Walks the alien across the tile grid one STEP per video frame. Every time
// the alien sits exactly on a tile it picks a new heading from the passable
// directions reported by terrain, preferring those that close on the player.
// A kill request parks the alien (invisible, frozen) for RESPAWN_FRAMES
// frames, after which it reappears at the spawn tile.
//
// Optional feature: define ALIEN_RANDOM_EN to add a 16-bit LFSR that, on
// roughly one decision in four, replaces the chase rules with a rotating
// pick of the first passable direction.
// ---------------------------------------------------------------------------
module alien_move #(
    parameter logic [10:0] BOARD_X        = 11'd32,
    parameter logic [10:0] BOARD_Y        = 11'd160,
    parameter int          BOARD_W        = 480,
    parameter int          BOARD_H        = 320,
    parameter int          TILE           = 32,
    parameter int          STEP           = 2,
    parameter int          INIT_COL       = 14,
    parameter int          INIT_ROW       = 0,
    parameter int          RESPAWN_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [3:0]  free_direction,
    input  logic [10:0] playerX,
    input  logic [10:0] playerY,
    input  logic        alien_hit,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  direction,
    output logic        alive
);

    // Heading encoding; it doubles as the bit index into free_direction.
    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    // Legal top-left range: the whole alien must stay on the board.
    localparam logic [10:0] MIN_X   = BOARD_X;
    localparam logic [10:0] MIN_Y   = BOARD_Y;
    localparam logic [10:0] MAX_X   = 11'(int'(BOARD_X) + BOARD_W - TILE);
    localparam logic [10:0] MAX_Y   = 11'(int'(BOARD_Y) + BOARD_H - TILE);
    localparam logic [10:0] SPAWN_X = 11'(int'(BOARD_X) + INIT_COL * TILE);
    localparam logic [10:0] SPAWN_Y = 11'(int'(BOARD_Y) + INIT_ROW * TILE);
    localparam logic [10:0] STEP_PX = 11'(STEP);
    localparam logic [10:0] TILE_PX = 11'(TILE);

    // Respawn counter holds 0 .. RESPAWN_FRAMES-1.
    localparam int               CNT_W    = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_DECIDE_WAIT = 2'd0,
        ST_DECIDE      = 2'd1,
        ST_MOVE        = 2'd2,
        ST_DEAD        = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      x_q, x_d;
    logic [10:0]      y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic             alive_q, alive_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decision datapath
    logic signed [11:0] dx, dy;
    logic [11:0]        dx_mag, dy_mag;
    logic [3:0]         can_move;
    logic [1:0]         h_dir, v_dir, prim_dir, sec_dir;
    logic               h_nz, v_nz, prim_nz, sec_nz;
    logic               choice_valid;
    logic [1:0]         choice_dir;

    // Stepping datapath
    logic [10:0] step_x, step_y;
    logic [10:0] x_off, y_off;
    logic        step_aligned;

    // A kill request is only honoured while the alien is alive.
    logic hit_take;
    assign hit_take = alien_hit && (state_q != ST_DEAD);

`ifdef ALIEN_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic [1:0]  rnd_dir;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced once per frame.
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = startOfFrame ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
    end

    // LFSR register, reloaded with its seed on reset.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`endif

    // Direction choice: chase rules with board clamping folded into can_move.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; an unassigned path in combinational logic infers a latch.
        dx = $signed({1'b0, playerX}) - $signed({1'b0, x_q});
        dy = $signed({1'b0, playerY}) - $signed({1'b0, y_q});
        dx_mag = dx[11] ? $unsigned(-dx) : $unsigned(dx);
        dy_mag = dy[11] ? $unsigned(-dy) : $unsigned(dy);

        // A heading off the board is blocked whatever terrain says.
        can_move            = 4'b0000;
        can_move[DIR_RIGHT] = free_direction[0] && (x_q < MAX_X);
        can_move[DIR_LEFT]  = free_direction[1] && (x_q > MIN_X);
        can_move[DIR_DOWN]  = free_direction[2] && (y_q < MAX_Y);
        can_move[DIR_UP]    = free_direction[3] && (y_q > MIN_Y);

        h_dir = dx[11] ? DIR_LEFT : DIR_RIGHT;
        v_dir = dy[11] ? DIR_UP   : DIR_DOWN;
        h_nz  = (dx != 12'sd0);
        v_nz  = (dy != 12'sd0);

        // Larger distance first; a tie favours the horizontal axis.
        if (dx_mag >= dy_mag) begin
            prim_dir = h_dir; prim_nz = h_nz;
            sec_dir  = v_dir; sec_nz  = v_nz;
        end else begin
            prim_dir = v_dir; prim_nz = v_nz;
            sec_dir  = h_dir; sec_nz  = h_nz;
        end

        choice_valid = 1'b1;
        choice_dir   = dir_q;
        if (prim_nz && can_move[prim_dir]) begin
            choice_dir = prim_dir;
        end else if (sec_nz && can_move[sec_dir]) begin
            choice_dir = sec_dir;
        end else if (can_move[dir_q]) begin
            choice_dir = dir_q;
        end else if (can_move[dir_q ^ 2'b01]) begin
            // Flipping bit 0 turns right<->left and down<->up.
            choice_dir = dir_q ^ 2'b01;
        end else begin
            choice_valid = 1'b0;
        end

`ifdef ALIEN_RANDOM_EN
        // Random override: scan up,down,left,right from index LFSR[3:2];
        // walking the scan backwards lets the first free entry win.
        rnd_dir = DIR_RIGHT;
        if (lfsr_q[1:0] == 2'b00) begin
            choice_valid = 1'b0;
            choice_dir   = dir_q;
            for (int k = 3; k >= 0; k--) begin
                rnd_dir = ~(lfsr_q[3:2] + 2'(k));
                if (can_move[rnd_dir]) begin
                    choice_valid = 1'b1;
                    choice_dir   = rnd_dir;
                end
            end
        end
`endif
    end

    // Candidate position one step along the current heading, and whether it lands on a tile.
    always_comb begin
        step_x = x_q;
        step_y = y_q;
        case (dir_q)
            DIR_RIGHT: step_x = x_q + STEP_PX;
            DIR_LEFT:  step_x = x_q - STEP_PX;
            DIR_DOWN:  step_y = y_q + STEP_PX;
            default:   step_y = y_q - STEP_PX;
        endcase
        x_off        = step_x - BOARD_X;
        y_off        = step_y - BOARD_Y;
        step_aligned = ((x_off % TILE_PX) == 11'd0) && ((y_off % TILE_PX) == 11'd0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) state_q <= ST_DECIDE_WAIT;
        else       state_q <= state_d;
    end

    // FSM next-state logic; a kill request overrides every live state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DECIDE_WAIT: state_d = ST_DECIDE;
            ST_DECIDE:      state_d = choice_valid ? ST_MOVE : ST_DECIDE_WAIT;
            ST_MOVE: begin
                if (startOfFrame && step_aligned) state_d = ST_DECIDE_WAIT;
            end
            ST_DEAD: begin
                if (startOfFrame && (cnt_q == CNT_LAST)) state_d = ST_DECIDE_WAIT;
            end
            default: state_d = ST_DECIDE_WAIT;
        endcase
        if (hit_take) state_d = ST_DEAD;
    end

    // FSM output logic: next values of position, heading, liveness and respawn count.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        alive_d = alive_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_DECIDE: begin
                if (choice_valid) dir_d = choice_dir;
            end
            ST_MOVE: begin
                if (startOfFrame) begin
                    x_d = step_x;
                    y_d = step_y;
                end
            end
            ST_DEAD: begin
                if (startOfFrame) begin
                    if (cnt_q == CNT_LAST) begin
                        x_d     = SPAWN_X;
                        y_d     = SPAWN_Y;
                        dir_d   = DIR_RIGHT;
                        alive_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // A hit freezes everything where it is, including a same-cycle step.
        if (hit_take) begin
            x_d     = x_q;
            y_d     = y_q;
            dir_d   = dir_q;
            alive_d = 1'b0;
            cnt_d   = '0;
        end
    end

    // Datapath registers, all returned to spawn values on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= SPAWN_X;
            y_q     <= SPAWN_Y;
            dir_q   <= DIR_RIGHT;
            alive_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            alive_q <= alive_d;
            cnt_q   <= cnt_d;
        end
    end

    assign topLeftX  = x_q;
    assign topLeftY  = y_q;
    assign direction = dir_q;
    assign alive     = alive_q;

endmodule

// File: tb/tb_alien_move.sv
// ---------------------------------------------------------------------------
// tb_alien_move -- directed self-checking bench for alien_move (default
// parameters, ALIEN_RANDOM_EN undefined). Spawn tile is (480,160), which is
// the right-most column and the top row of the board, so both the right and
// the up headings are clamped there.
// ---------------------------------------------------------------------------
module tb_alien_move;

    logic        clk;
    logic        reset;
    logic        sof;
    logic [3:0]  free_dir;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic        hit;
    logic [10:0] top_left_x;
    logic [10:0] top_left_y;
    logic [1:0]  dir;
    logic        alive;

    int checks = 0;
    int errors = 0;

    alien_move dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (sof),
        .free_direction (free_dir),
        .playerX        (player_x),
        .playerY        (player_y),
        .alien_hit      (hit),
        .topLeftX       (top_left_x),
        .topLeftY       (top_left_y),
        .direction      (dir),
        .alive          (alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: a one-cycle startOfFrame pulse followed by three idle cycles.
    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset    = 1'b1;
        sof      = 1'b0;
        hit      = 1'b0;
        free_dir = 4'b1111;
        player_x = 11'd576;
        player_y = 11'd160;
        tick();
        tick();

        // Reset values
        check("reset_x",     32'(top_left_x), 32'd480);
        check("reset_y",     32'(top_left_y), 32'd160);
        check("reset_dir",   32'(dir),        32'd0);
        check("reset_alive", 32'(alive),      32'd1);
        reset = 1'b0;

        // Player to the right, but x=480 is the right edge: right is clamped,
        // heading right is clamped too, so the reverse (left) is taken.
        tick();
        tick();
        check("clamp_right_dir", 32'(dir),        32'd1);
        check("clamp_right_x",   32'(top_left_x), 32'd480);

        // One frame moves one STEP, visible one cycle after the pulse.
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("step1_x", 32'(top_left_x), 32'd478);
        check("step1_y", 32'(top_left_y), 32'd160);
        tick();
        tick();
        tick();

        // 16 frames per tile. Before the aligning frame, aim the player
        // left-down (|dx|>|dy|) with only down free: rule 2 picks down.
        frames(14);
        player_x = 11'd320;
        player_y = 11'd192;
        free_dir = 4'b0100;
        frame();
        check("tile_x",         32'(top_left_x), 32'd448);
        check("second_axis_dir", 32'(dir),       32'd2);

        frame();
        check("down_y", 32'(top_left_y), 32'd162);
        check("down_x", 32'(top_left_x), 32'd448);

        // Land on (448,192) with nothing free: the alien must stay put.
        frames(14);
        free_dir = 4'b0000;
        frame();
        frames(10);
        check("blocked_x",   32'(top_left_x), 32'd448);
        check("blocked_y",   32'(top_left_y), 32'd192);
        check("blocked_dir", 32'(dir),        32'd2);

        // Player below-left with |dy|>|dx|, only left free: left chosen.
        player_x = 11'd416;
        player_y = 11'd320;
        free_dir = 4'b0010;
        tick();
        tick();
        tick();
        check("only_left_dir", 32'(dir), 32'd1);

        // At (416,192) dx=0, down blocked: heading (left) is kept.
        frames(16);
        check("left_tile_x", 32'(top_left_x), 32'd416);
        check("keep_dir",    32'(dir),        32'd1);

        // Walk all the way to the left edge; left is then clamped and nothing
        // else is free, so x stays at 32.
        frames(196);
        check("left_edge_x", 32'(top_left_x), 32'd32);

        // Player off the board to the left, all free: left still refused,
        // reverse (right) taken.
        player_x = 11'd0;
        player_y = 11'd192;
        free_dir = 4'b1111;
        tick();
        tick();
        tick();
        check("left_edge_dir",  32'(dir),        32'd0);
        check("left_edge_hold", 32'(top_left_x), 32'd32);
        frame();
        check("left_edge_step", 32'(top_left_x), 32'd34);

        // Hit together with startOfFrame mid-tile: dead, no step.
        sof = 1'b1;
        hit = 1'b1;
        tick();
        sof = 1'b0;
        hit = 1'b0;
        check("hit_alive", 32'(alive),      32'd0);
        check("hit_x",     32'(top_left_x), 32'd34);
        tick();
        tick();

        // 119 frames dead, with a stray hit in the middle that must be ignored.
        frames(59);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        frames(60);
        check("dead_alive_119", 32'(alive),      32'd0);
        check("dead_frozen_x",  32'(top_left_x), 32'd34);

        // 120th frame respawns at the spawn tile heading right.
        player_x = 11'd480;
        player_y = 11'd0;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("respawn_alive", 32'(alive),      32'd1);
        check("respawn_x",     32'(top_left_x), 32'd480);
        check("respawn_y",     32'(top_left_y), 32'd160);
        check("respawn_dir",   32'(dir),        32'd0);

        // Player straight above the top row: up and right both clamped, left taken.
        tick();
        tick();
        tick();
        check("clamp_top_dir", 32'(dir), 32'd1);
        frame();
        check("clamp_top_x", 32'(top_left_x), 32'd478);

        // Reset during DEAD frame 50 returns straight to spawn values.
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit2_alive", 32'(alive), 32'd0);
        frames(50);
        reset = 1'b1;
        tick();
        check("rst_dead_alive", 32'(alive),      32'd1);
        check("rst_dead_x",     32'(top_left_x), 32'd480);
        check("rst_dead_y",     32'(top_left_y), 32'd160);
        check("rst_dead_dir",   32'(dir),        32'd0);
        reset = 1'b0;

        // A fresh death after reset needs the full 120 frames again.
        tick();
        tick();
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        frames(119);
        check("dead2_alive_119", 32'(alive), 32'd0);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("dead2_alive_120", 32'(alive), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
